// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller slice.
//   - default address/data/byte-enable/burst widths used by dcache_ctrl
//   - controller state encoding
//   - clog2 helper for sizing index and counter fields
package dcache_pkg;

    localparam int DEF_ADDRBITS = 32;
    localparam int DEF_DATABITS = 32;
    localparam int DEF_BANKNUM  = 4;
    localparam int DEF_BURSTLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_REPLAY = 2'd3
    } state_t;

    // Ceiling log2, never less than 1 so a field always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dcache_mem_mux.sv
// Routes the single memory-controller port to the line that currently owns it.
//   owner, owner_vld      : index of the owning line and whether any line owns the port
//   line_out              : per-line data out (write-back data source)
//   line_mem_addr/rdreq/wrreq : per-line memory request signals
//   mem_valid             : memory read-data strobe, demuxed to the owner only
//   mem_addr/datain/rdreq/wrreq : owner's request signals, all 0 without an owner
//   line_mem_valid        : one-hot copy of mem_valid for the owner line
module dcache_mem_mux #(
    parameter int NUMLINES = 4,
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32,
    parameter int OWNW     = 2
) (
    input  logic [OWNW-1:0]            owner,
    input  logic                       owner_vld,
    input  logic [NUMLINES*DATABITS-1:0] line_out,
    input  logic [NUMLINES*ADDRBITS-1:0] line_mem_addr,
    input  logic [NUMLINES-1:0]        line_mem_rdreq,
    input  logic [NUMLINES-1:0]        line_mem_wrreq,
    input  logic                       mem_valid,
    output logic [ADDRBITS-1:0]        mem_addr,
    output logic [DATABITS-1:0]        mem_datain,
    output logic                       mem_rdreq,
    output logic                       mem_wrreq,
    output logic [NUMLINES-1:0]        line_mem_valid
);

    // Purely combinational so an asynchronous reset of owner_vld drops the
    // memory requests in the same cycle.
    always_comb begin
        mem_addr       = '0;
        mem_datain     = '0;
        mem_rdreq      = 1'b0;
        mem_wrreq      = 1'b0;
        line_mem_valid = '0;
        for (int i = 0; i < NUMLINES; i++) begin
            if (owner_vld && (owner == OWNW'(i))) begin
                mem_addr          = line_mem_addr[i*ADDRBITS +: ADDRBITS];
                mem_datain        = line_out[i*DATABITS +: DATABITS];
                mem_rdreq         = line_mem_rdreq[i];
                mem_wrreq         = line_mem_wrreq[i];
                line_mem_valid[i] = mem_valid;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller in front of NUMLINES dcache_line instances.
// One CPU load/store is accepted at a time, latched and broadcast to every
// line. A hit returns the lowest-index hitting line's data; an all-miss picks
// a round-robin victim, pulses its refill, hands it the memory port for one
// burst and then replays the latched access.
//   CPU side   : cpu_addr/datain/be/rdreq/wrreq in, cpu_dataout/valid/busy out
//   Line side  : line_addr/datain/be/rdreq/wrreq/fill out (broadcast / one-hot),
//                line_out/valid/miss/mem_addr/mem_rdreq/mem_wrreq in,
//                line_mem_valid out
//   Memory side: mem_out/mem_valid in, mem_burstlen/addr/datain/rdreq/wrreq out
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUMLINES = 4,
    parameter int ADDRBITS = DEF_ADDRBITS,
    parameter int DATABITS = DEF_DATABITS,
    parameter int BANKNUM  = DEF_BANKNUM,
    parameter int BURSTLEN = DEF_BURSTLEN
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRBITS-1:0]          cpu_addr,
    input  logic [DATABITS-1:0]          cpu_datain,
    input  logic                         cpu_rdreq,
    input  logic                         cpu_wrreq,
    input  logic [BANKNUM-1:0]           cpu_be,
    output logic [DATABITS-1:0]          cpu_dataout,
    output logic                         cpu_valid,
    output logic                         cpu_busy,
    output logic [ADDRBITS-1:0]          line_addr,
    output logic [DATABITS-1:0]          line_datain,
    output logic [BANKNUM-1:0]           line_be,
    output logic                         line_rdreq,
    output logic                         line_wrreq,
    output logic [NUMLINES-1:0]          line_fill,
    input  logic [NUMLINES*DATABITS-1:0] line_out,
    input  logic [NUMLINES-1:0]          line_valid,
    input  logic [NUMLINES-1:0]          line_miss,
    input  logic [NUMLINES*ADDRBITS-1:0] line_mem_addr,
    input  logic [NUMLINES-1:0]          line_mem_rdreq,
    input  logic [NUMLINES-1:0]          line_mem_wrreq,
    output logic [NUMLINES-1:0]          line_mem_valid,
    input  logic [DATABITS-1:0]          mem_out,
    input  logic                         mem_valid,
    output logic [15:0]                  mem_burstlen,
    output logic [ADDRBITS-1:0]          mem_addr,
    output logic [DATABITS-1:0]          mem_datain,
    output logic                         mem_rdreq,
    output logic                         mem_wrreq
);

    localparam int OWNW = clog2(NUMLINES);
    localparam int CNTW = clog2(BURSTLEN + 1);
    localparam logic [CNTW-1:0] BEATS_FULL = CNTW'(BURSTLEN);
    localparam logic [OWNW-1:0] LAST_LINE  = OWNW'(NUMLINES - 1);

    state_t state, state_d;

    logic                op_wr;
    logic [OWNW-1:0]     victim;
    logic [OWNW-1:0]     owner;
    logic                owner_vld;
    logic [NUMLINES-1:0] miss_acc;
    logic [CNTW-1:0]     beat_cnt;
    logic                rd_seen;

    logic                hit_any;
    logic [DATABITS-1:0] hit_data;
    logic                all_miss;
    logic                accept;
    logic                issue;
    logic                issue_wr;
    logic                lookup_hit;
    logic                lookup_miss;
    logic                fill_done;
    logic                beat;

    // mem_out is fanned out to the lines outside this block; the controller
    // itself never consumes the read data.
    logic                unused_mem_out;
    assign unused_mem_out = ^mem_out;

    assign mem_burstlen = 16'(BURSTLEN);

    // Lowest-index hitting line wins: scan downward so the last write is index 0 side.
    always_comb begin
        hit_any  = |line_valid;
        hit_data = '0;
        for (int i = NUMLINES - 1; i >= 0; i--) begin
            if (line_valid[i]) hit_data = line_out[i*DATABITS +: DATABITS];
        end
    end

    // Lines may answer in different cycles; misses seen earlier in this
    // lookup are remembered so all-miss is the union over the whole lookup.
    assign all_miss = &(miss_acc | line_miss);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (cpu_rdreq || cpu_wrreq) state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (hit_any)       state_d = ST_IDLE;
                else if (all_miss) state_d = ST_FILL;
            end
            ST_FILL:   if (beat_cnt == BEATS_FULL) state_d = ST_REPLAY;
            ST_REPLAY: state_d = ST_LOOKUP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept      = (state == ST_IDLE) && (cpu_rdreq || cpu_wrreq);
        issue       = accept || (state == ST_REPLAY);
        // A fresh request takes its op from the CPU pins (write wins over
        // read); a replay reuses the latched op.
        issue_wr    = accept ? cpu_wrreq : op_wr;
        lookup_hit  = (state == ST_LOOKUP) && hit_any;
        lookup_miss = (state == ST_LOOKUP) && !hit_any && all_miss;
        fill_done   = (state == ST_FILL) && (beat_cnt == BEATS_FULL);
        // Only read-data beats of the refill count; write-back traffic and
        // anything after the burst is complete are ignored.
        beat        = (state == ST_FILL) && mem_valid && !mem_wrreq &&
                      (rd_seen || mem_rdreq) && (beat_cnt != BEATS_FULL);
        cpu_busy    = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_addr   <= '0;
            line_datain <= '0;
            line_be     <= '0;
            op_wr       <= 1'b0;
            line_rdreq  <= 1'b0;
            line_wrreq  <= 1'b0;
            line_fill   <= '0;
            cpu_valid   <= 1'b0;
            cpu_dataout <= '0;
            miss_acc    <= '0;
            victim      <= '0;
            owner       <= '0;
            owner_vld   <= 1'b0;
            beat_cnt    <= '0;
            rd_seen     <= 1'b0;
        end else begin
            if (accept) begin
                line_addr   <= cpu_addr;
                line_datain <= cpu_datain;
                line_be     <= cpu_be;
                op_wr       <= cpu_wrreq;
            end

            line_rdreq <= issue && !issue_wr;
            line_wrreq <= issue && issue_wr;

            if (issue)                   miss_acc <= '0;
            else if (state == ST_LOOKUP) miss_acc <= miss_acc | line_miss;

            cpu_valid <= lookup_hit;
            if (lookup_hit && !op_wr) cpu_dataout <= hit_data;

            line_fill <= lookup_miss ? (NUMLINES'(1) << victim) : '0;

            if (lookup_miss) begin
                owner     <= victim;
                owner_vld <= 1'b1;
                beat_cnt  <= '0;
                rd_seen   <= 1'b0;
            end else begin
                if ((state == ST_FILL) && mem_rdreq) rd_seen  <= 1'b1;
                if (beat)                            beat_cnt <= beat_cnt + CNTW'(1);
            end

            if (fill_done) begin
                owner_vld <= 1'b0;
                victim    <= (victim == LAST_LINE) ? '0 : victim + OWNW'(1);
            end
        end
    end

    dcache_mem_mux #(
        .NUMLINES (NUMLINES),
        .ADDRBITS (ADDRBITS),
        .DATABITS (DATABITS),
        .OWNW     (OWNW)
    ) u_mem_mux (
        .owner          (owner),
        .owner_vld      (owner_vld),
        .line_out       (line_out),
        .line_mem_addr  (line_mem_addr),
        .line_mem_rdreq (line_mem_rdreq),
        .line_mem_wrreq (line_mem_wrreq),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_datain     (mem_datain),
        .mem_rdreq      (mem_rdreq),
        .mem_wrreq      (mem_wrreq),
        .line_mem_valid (line_mem_valid)
    );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl. The driver steps one cycle at a time just
// after each rising edge, sets the inputs, and records what the controller
// must be showing in that cycle (busy, pulses, latched request, routing owner).
// A compare process checks every output against those expectations on each
// falling edge; literal checks pin key values by hand.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_datain;
    logic        cpu_rdreq, cpu_wrreq;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_dataout;
    logic        cpu_valid, cpu_busy;
    logic [31:0] line_addr, line_datain;
    logic [3:0]  line_be;
    logic        line_rdreq, line_wrreq;
    logic [3:0]  line_fill;
    logic [3:0][31:0] line_out_b;
    logic [3:0]  line_valid, line_miss;
    logic [3:0][31:0] line_mem_addr_b;
    logic [3:0]  line_mem_rdreq_b, line_mem_wrreq_b;
    logic [3:0]  line_mem_valid;
    logic [31:0] mem_out;
    logic        mem_valid;
    logic [15:0] mem_burstlen;
    logic [31:0] mem_addr, mem_datain;
    logic        mem_rdreq, mem_wrreq;

    dcache_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_datain     (cpu_datain),
        .cpu_rdreq      (cpu_rdreq),
        .cpu_wrreq      (cpu_wrreq),
        .cpu_be         (cpu_be),
        .cpu_dataout    (cpu_dataout),
        .cpu_valid      (cpu_valid),
        .cpu_busy       (cpu_busy),
        .line_addr      (line_addr),
        .line_datain    (line_datain),
        .line_be        (line_be),
        .line_rdreq     (line_rdreq),
        .line_wrreq     (line_wrreq),
        .line_fill      (line_fill),
        .line_out       (line_out_b),
        .line_valid     (line_valid),
        .line_miss      (line_miss),
        .line_mem_addr  (line_mem_addr_b),
        .line_mem_rdreq (line_mem_rdreq_b),
        .line_mem_wrreq (line_mem_wrreq_b),
        .line_mem_valid (line_mem_valid),
        .mem_out        (mem_out),
        .mem_valid      (mem_valid),
        .mem_burstlen   (mem_burstlen),
        .mem_addr       (mem_addr),
        .mem_datain     (mem_datain),
        .mem_rdreq      (mem_rdreq),
        .mem_wrreq      (mem_wrreq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Expected controller-visible state for the current cycle.
    bit          m_busy, m_rd, m_wr, m_cv, m_fill, m_opwr;
    logic [3:0]  m_fill_vec;
    logic [31:0] m_dout, m_addr, m_din;
    logic [3:0]  m_be;
    int          m_owner, m_victim;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_rd = 0; m_wr = 0; m_cv = 0; m_fill = 0; m_opwr = 0;
        m_fill_vec = '0; m_dout = '0; m_addr = '0; m_din = '0; m_be = '0;
        m_owner = 0; m_victim = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] e_addr, e_dat;
            logic        e_rd, e_wr;
            logic [3:0]  e_lmv;
            e_addr = m_fill ? line_mem_addr_b[m_owner]  : 32'h0;
            e_dat  = m_fill ? line_out_b[m_owner]       : 32'h0;
            e_rd   = m_fill ? line_mem_rdreq_b[m_owner] : 1'b0;
            e_wr   = m_fill ? line_mem_wrreq_b[m_owner] : 1'b0;
            e_lmv  = (m_fill && mem_valid) ? (4'b0001 << m_owner) : 4'b0000;
            check("cpu_busy",     cpu_busy,       m_busy);
            check("line_rdreq",   line_rdreq,     m_rd);
            check("line_wrreq",   line_wrreq,     m_wr);
            check("line_fill",    line_fill,      m_fill_vec);
            check("cpu_valid",    cpu_valid,      m_cv);
            check("cpu_dataout",  cpu_dataout,    m_dout);
            check("mem_rdreq",    mem_rdreq,      e_rd);
            check("mem_wrreq",    mem_wrreq,      e_wr);
            check("mem_addr",     mem_addr,       e_addr);
            check("mem_datain",   mem_datain,     e_dat);
            check("line_mem_vld", line_mem_valid, e_lmv);
            check("mem_burstlen", mem_burstlen,   64'd32);
            if (m_busy) begin
                check("line_addr",   line_addr,   m_addr);
                check("line_datain", line_datain, m_din);
                check("line_be",     line_be,     m_be);
            end
        end
    end

    // Advance one cycle; single-cycle inputs and pulse expectations fall back to 0.
    task automatic cyc();
        @(posedge clk);
        #1;
        cpu_rdreq = 0; cpu_wrreq = 0; line_valid = '0; line_miss = '0; mem_valid = 0;
        m_rd = 0; m_wr = 0; m_cv = 0; m_fill_vec = '0;
    endtask

    // Issue a request from IDLE; returns in the lookup cycle after the broadcast pulse.
    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        cpu_rdreq = rd; cpu_wrreq = wr; cpu_addr = a; cpu_datain = d; cpu_be = be;
        cyc();
        m_busy = 1; m_addr = a; m_din = d; m_be = be; m_opwr = wr;
        m_rd = !wr; m_wr = wr;
        cyc();
    endtask

    // Lines in vec hit, the rest miss; returns in the cpu_valid cycle.
    task automatic hit(input logic [3:0] vec);
        logic [31:0] first;
        first = '0;
        for (int i = 3; i >= 0; i--) if (vec[i]) first = line_out_b[i];
        line_valid = vec; line_miss = ~vec;
        cyc();
        m_cv = 1; m_busy = 0;
        if (!m_opwr) m_dout = first;
    endtask

    // Every line misses; returns in the fill entry cycle.
    task automatic miss();
        line_miss = 4'b1111;
        cyc();
        m_fill = 1; m_owner = m_victim; m_fill_vec = 4'b0001 << m_victim;
    endtask

    // Optional write-back words, then 32 read beats (optionally a gap after
    // beat 3), then the replay; returns in the lookup cycle after the replay pulse.
    task automatic burst(input int wb, input bit gap, input logic [31:0] faddr);
        if (wb > 0) begin
            line_mem_wrreq_b[m_owner] = 1;
            line_mem_addr_b[m_owner]  = 32'h7777_0000;
            line_out_b[m_owner]       = 32'hdeadbeef;
            mem_valid = 1;
            #1;
            check("wb_wrreq", mem_wrreq,  1);
            check("wb_rdreq", mem_rdreq,  0);
            check("wb_data",  mem_datain, 32'hdeadbeef);
            check("wb_addr",  mem_addr,   32'h7777_0000);
            for (int w = 0; w < wb; w++) begin
                mem_valid = 1;
                cyc();
            end
            line_mem_wrreq_b[m_owner] = 0;
        end
        line_mem_rdreq_b[m_owner] = 1;
        line_mem_addr_b[m_owner]  = faddr;
        for (int b = 1; b <= 32; b++) begin
            mem_valid = 1;
            mem_out   = 32'hf000_0000 + b;
            cyc();
            if (gap && b == 3) cyc();
        end
        line_mem_rdreq_b[m_owner] = 0;
        cyc();
        m_fill = 0; m_victim = (m_victim + 1) % 4;
        cyc();
        m_rd = !m_opwr; m_wr = m_opwr;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1;
        line_mem_rdreq_b = '0; line_mem_wrreq_b = '0;
        model_reset();
        cyc();
        cyc();
        reset = 0;
        cyc();
    endtask

    initial begin
        logic [3:0] fill_tbl [5];
        fill_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1;
        cpu_addr = '0; cpu_datain = '0; cpu_rdreq = 0; cpu_wrreq = 0; cpu_be = '0;
        line_out_b = '0; line_valid = '0; line_miss = '0; line_mem_addr_b = '0;
        line_mem_rdreq_b = '0; line_mem_wrreq_b = '0; mem_out = '0; mem_valid = 0;
        model_reset();
        cyc();
        chk_en = 1;
        #1;
        check("rst_busy",  cpu_busy,  0);
        check("rst_valid", cpu_valid, 0);
        check("rst_fill",  line_fill, 0);
        check("rst_memrd", mem_rdreq, 0);
        check("rst_laddr", line_addr, 0);
        cyc();
        reset = 0;
        cyc();

        // Read hit on line 2; a request arriving while busy is ignored.
        line_out_b[2] = 32'h12345678;
        req(1, 0, 32'h0000_1040, 32'h0, 4'hf);
        cpu_rdreq = 1; cpu_addr = 32'h5555_0000;
        hit(4'b0100);
        #1;
        check("hit_data",  cpu_dataout, 32'h12345678);
        check("hit_valid", cpu_valid,   1);

        // Read miss with a gap in the burst; victim 0, then replay hits.
        req(1, 0, 32'hd00faffc, 32'h0, 4'hf);
        miss();
        #1;
        check("miss_fill0", line_fill, 4'b0001);
        check("miss_addr",  line_addr, 32'hd00faffc);
        burst(0, 1, 32'hd00faf80);
        line_out_b[0] = 32'hcafe0001;
        hit(4'b0001);
        #1;
        check("refill_data", cpu_dataout, 32'hcafe0001);

        // Multi-hit: lines 1 and 3, line 1 wins.
        line_out_b[1] = 32'haaaa1111;
        line_out_b[3] = 32'hbbbb3333;
        req(1, 0, 32'h0000_2000, 32'h0, 4'hf);
        hit(4'b1010);
        #1;
        check("multihit", cpu_dataout, 32'haaaa1111);

        // Read and write together: only the write is broadcast; store hit
        // acknowledges without touching cpu_dataout.
        cpu_rdreq = 1; cpu_wrreq = 1; cpu_addr = 32'h0000_3000;
        cpu_datain = 32'h0badf00d; cpu_be = 4'b0011;
        cyc();
        m_busy = 1; m_addr = 32'h0000_3000; m_din = 32'h0badf00d; m_be = 4'b0011;
        m_opwr = 1; m_wr = 1;
        #1;
        check("both_rd", line_rdreq, 0);
        check("both_wr", line_wrreq, 1);
        cyc();
        hit(4'b0001);
        #1;
        check("st_valid", cpu_valid,   1);
        check("st_dout",  cpu_dataout, 32'haaaa1111);

        // Store miss with write-back on the next victim (line 1).
        req(0, 1, 32'h4444_0010, 32'h11223344, 4'hf);
        miss();
        #1;
        check("wb_fill1", line_fill, 4'b0010);
        burst(3, 0, 32'h4444_0000);
        hit(4'b0010);
        #1;
        check("st2_dout", cpu_dataout, 32'haaaa1111);

        // Five consecutive misses from reset walk the victim pointer and wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req(1, 0, 32'h0001_0000 + 32'(i) * 32'h100, 32'h0, 4'hf);
            miss();
            #1;
            check("rr_fill", line_fill, fill_tbl[i]);
            burst(0, 0, 32'h0001_0000 + 32'(i) * 32'h100);
            hit(4'b0001);
        end

        // Reset in the middle of a burst drops the memory request at once.
        req(1, 0, 32'h0002_0000, 32'h0, 4'hf);
        miss();
        line_mem_rdreq_b[m_owner] = 1;
        line_mem_addr_b[m_owner]  = 32'h0002_0000;
        for (int b = 0; b < 10; b++) begin
            mem_valid = 1;
            cyc();
        end
        mem_valid = 1;
        reset = 1;
        model_reset();
        #1;
        check("rstfill_memrd", mem_rdreq,      0);
        check("rstfill_busy",  cpu_busy,       0);
        check("rstfill_lmv",   line_mem_valid, 0);
        cyc();
        cyc();
        line_mem_rdreq_b = '0;
        reset = 0;
        cyc();
        req(1, 0, 32'h0003_0000, 32'h0, 4'hf);
        miss();
        #1;
        check("post_rst_fill", line_fill, 4'b0001);
        burst(0, 0, 32'h0003_0000);
        hit(4'b0001);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
